float_to_fixed_param: RTL and testbench
=======================================

Name: float_to_fixed_param

Overview:
Parametrised IEEE-754-style float to two's-complement fixed-point converter. It is the successor to the fixed single-precision normaliser, with these additions:
- Float and fixed formats are generic.
- Saturation, NaN/Inf handling and optional round-to-nearest-even.
It keeps the codebase's Begin/ACK FSM handshake and sits between float datapaths and fixed-point CORDIC/arithmetic units.

Parameters:
- EXP_W, 8: float exponent width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: float stored mantissa width, with hidden bit implied.
- INT_W, 8: fixed integer bits, including the sign bit.
- FRAC_W, 24: fixed fraction bits; OUT_W = INT_W+FRAC_W.

Ports:
- CLK, input, 1: system clock, rising edge.
- RST_FF_N, input, 1: asynchronous active-low reset.
- RST_FSM_FF, input, 1: synchronous active-high FSM clear.
- Begin_FSM_FF, input, 1: start request, sampled in IDLE.
- F, input, EXP_W+MAN_W+1: float operand {sign, exp, man}.
- ACK_FF, output, 1: conversion done, RESULT valid.
- RESULT, output, OUT_W: fixed-point result.
- OVF_FF, output, 1: result saturated (overflow or Inf).
- NAN_FF, output, 1: operand was NaN.

Behaviour:
- Async reset (RST_FF_N=0): FSM to IDLE; ACK_FF, RESULT, OVF_FF, NAN_FF and all internal registers are 0. This applies immediately, including mid-conversion.
- RST_FSM_FF=1 at an edge:
  - FSM goes to IDLE and ACK_FF goes to 0.
  - RESULT, OVF_FF and NAN_FF hold.
  - It has priority over Begin_FSM_FF.
- States: IDLE -> DECODE -> ALIGN -> ROUND -> SAT -> DONE.
- IDLE: when Begin_FSM_FF=1, capture F into the operand register and go to DECODE. Begin_FSM_FF is ignored in every other state.
- DECODE:
  - Unbiased e = exp-BIAS.
  - Significand = {1, man}, MAN_W+1 bits.
  - Shift amount s = e+FRAC_W-MAN_W, signed.
  - Classify the operand as zero/denormal (exp=0), Inf (exp all 1s, man=0), NaN (exp all 1s, man!=0) or normal.
- ALIGN:
  - s>=0: shift the significand left by s into an OUT_W+1 bit magnitude register. If any bit would land at or above bit OUT_W, set the internal overflow flag.
  - s<0: shift right by -s, keeping guard bit G and sticky S (OR of the remaining shifted-out bits). If -s > MAN_W+2, the magnitude becomes 0 and S = 1.
- ROUND:
  - With ROUND_NEAREST_EN: magnitude += G & (S | lsb).
  - Without: truncate, i.e. magnitude unchanged.
  - A carry may set the overflow flag.
- SAT (sign and saturate):
  - Limit is 2^(OUT_W-1)-1 for positive and 2^(OUT_W-1) for negative.
  - Magnitude > limit, or Inf: RESULT = 0x7F..F (positive) or 0x80..0 (negative), and OVF_FF=1.
  - Otherwise: RESULT = sign ? -magnitude : magnitude, and OVF_FF=0.
  - Zero/denormal: RESULT=0, OVF_FF=0 (flush to zero; -0 gives 0).
  - NaN: RESULT=0, NAN_FF=1, OVF_FF=0.
  - For non-NaN operands NAN_FF=0.
- DONE: ACK_FF=1, registered, with RESULT, OVF_FF and NAN_FF registered on the same edge.
  - Stay in DONE while Begin_FSM_FF=1; go to IDLE on the first edge with Begin_FSM_FF=0.
  - A one-cycle Begin pulse therefore gives a one-cycle ACK_FF.
- Latency: count the edge that samples Begin_FSM_FF as edge 1. ACK_FF rises after edge 5. Throughput is one conversion per 6 cycles minimum.
- Output hold: RESULT and the flags hold until the next SAT edge or reset. ACK_FF drops on the IDLE transition.
- F may change after capture without affecting the conversion.
- Shift logic is sized for the full range of s; the exponent range never wraps.

Optional Feature:
- Macro: ROUND_NEAREST_EN.
- Defined: round-half-to-even on the bits discarded by right shifts, as in the ROUND state above.
- Undefined: truncation toward zero of the magnitude. G/S logic and the rounding adder are removed; latency is unchanged because the ROUND state is kept as a pass-through.

Test Plan (defaults, OUT_W=32):
- F=0xBF800000 (-1.0), one-cycle Begin -> RESULT=0xFF000000, OVF_FF=0, NAN_FF=0; ACK_FF high for exactly 1 cycle after edge 5.
- F=0x3F933333 (1.15) -> 0x01266666. F=0x41740000 (15.25) -> 0x0F400000. F=0xC1740000 (-15.25) -> 0xF0C00000.
- F=0x3C9374BC (0.018) -> 0x00049BA6 with ROUND_NEAREST_EN, 0x00049BA5 without.
- Saturation:
  - F=0x43480000 (200.0) -> 0x7FFFFFFF, OVF_FF=1.
  - F=0xC3000000 (-128.0) -> 0x80000000, OVF_FF=0.
  - F=0xFF800000 (-Inf) -> 0x80000000, OVF_FF=1.
- Specials:
  - F=0x7FC00000 (NaN) -> RESULT=0, NAN_FF=1.
  - F=0x00000001 (denormal) -> RESULT=0, no flags.
  - Begin held high 4 cycles -> ACK_FF held until the edge after Begin falls; no second conversion starts.
- Resets:
  - RST_FF_N pulsed low during ALIGN -> all outputs 0 immediately, FSM in IDLE; a new Begin then converts normally.
  - RST_FSM_FF during ROUND -> no ACK_FF, previous RESULT held.

Source files
------------

// File: rtl/float_to_fixed_param.sv
// Parametrised float -> two's-complement fixed converter with Begin/ACK handshake.
// Define ROUND_NEAREST_EN for round-half-to-even; otherwise the magnitude is truncated.
module float_to_fixed_param #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int INT_W  = 8,
    parameter int FRAC_W = 24
) (
    input  logic                     CLK,
    input  logic                     RST_FF_N,
    input  logic                     RST_FSM_FF,
    input  logic                     Begin_FSM_FF,
    input  logic [EXP_W+MAN_W:0]     F,
    output logic                     ACK_FF,
    output logic [INT_W+FRAC_W-1:0]  RESULT,
    output logic                     OVF_FF,
    output logic                     NAN_FF
);

    localparam int OUT_W  = INT_W + FRAC_W;
    localparam int BIAS   = 2**(EXP_W-1) - 1;
    localparam int SIG_W  = MAN_W + 1;
    localparam int WIDE_W = OUT_W + MAN_W + 2;
    localparam int SHA_W  = $clog2(WIDE_W) + 1;
    localparam int SH_W   = EXP_W + SHA_W + 2;
    localparam int RSA_W  = $clog2(MAN_W + 3) + 1;
    localparam int SH_OFS = BIAS + MAN_W - FRAC_W;

    localparam logic signed [SH_W-1:0] L_OVF_S   = SH_W'(OUT_W - MAN_W);
    localparam logic signed [SH_W-1:0] R_FLUSH_S = SH_W'(MAN_W + 2);
    localparam logic [OUT_W:0] LIM_POS = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0] LIM_NEG = {2'b01, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_ALIGN, S_ROUND, S_SAT, S_DONE
    } state_t;

    state_t                   r_state, w_next;
    logic                     r_ack;
    logic [EXP_W+MAN_W:0]     r_op;
    logic                     r_sign, r_zero, r_inf, r_nan;
    logic [SIG_W-1:0]         r_sig;
    logic signed [SH_W-1:0]   r_shift;
    logic [OUT_W:0]           r_mag;
    logic                     r_ovf;
    logic [OUT_W-1:0]         r_result;
    logic                     r_ovf_out, r_nan_out;
`ifdef ROUND_NEAREST_EN
    logic                     r_g, r_s;
    logic                     w_al_g, w_al_s;
    logic [2*MAN_W+3:0]       w_rtmp;
`endif

    logic [EXP_W-1:0]         w_exp;
    logic [MAN_W-1:0]         w_man;
    logic signed [SH_W-1:0]   w_shift, w_neg_shift;
    logic                     w_exp_ones, w_exp_zero, w_man_zero;
    logic [WIDE_W-1:0]        w_wide;
    logic [SIG_W-1:0]         w_rq;
    logic [OUT_W:0]           w_al_mag, w_rnd_mag, w_lim;
    logic                     w_al_ovf, w_rnd_ovf, w_sat;
    logic [OUT_W-1:0]         w_sat_val, w_signed;

    assign w_exp       = r_op[EXP_W+MAN_W-1:MAN_W];
    assign w_man       = r_op[MAN_W-1:0];
    assign w_exp_ones  = &w_exp;
    assign w_exp_zero  = ~|w_exp;
    assign w_man_zero  = ~|w_man;
    assign w_shift     = $signed(SH_W'(w_exp)) - $signed(SH_W'(SH_OFS));
    assign w_neg_shift = -r_shift;

    // Left shifts overflow as soon as the hidden bit reaches bit OUT_W; right shifts
    // beyond MAN_W+2 leave only sticky information.
    always_comb begin
        w_al_mag = '0;
        w_al_ovf = 1'b0;
        w_wide   = '0;
        w_rq     = '0;
`ifdef ROUND_NEAREST_EN
        w_al_g   = 1'b0;
        w_al_s   = 1'b0;
        w_rtmp   = '0;
`endif
        if (!r_shift[SH_W-1]) begin
            if (r_shift >= L_OVF_S) begin
                w_al_ovf = 1'b1;
            end else begin
                w_wide   = WIDE_W'(r_sig) << r_shift[SHA_W-1:0];
                w_al_mag = w_wide[OUT_W:0];
            end
        end else if (w_neg_shift > R_FLUSH_S) begin
`ifdef ROUND_NEAREST_EN
            w_al_s = 1'b1;
`endif
        end else begin
`ifdef ROUND_NEAREST_EN
            w_rtmp = {r_sig, {(MAN_W+3){1'b0}}} >> w_neg_shift[RSA_W-1:0];
            w_rq   = w_rtmp[2*MAN_W+3 -: SIG_W];
            w_al_g = w_rtmp[MAN_W+2];
            w_al_s = |w_rtmp[MAN_W+1:0];
`else
            w_rq   = r_sig >> w_neg_shift[RSA_W-1:0];
`endif
            w_wide   = WIDE_W'(w_rq);
            w_al_ovf = |(w_wide >> OUT_W);
            w_al_mag = w_wide[OUT_W:0];
        end
    end

`ifdef ROUND_NEAREST_EN
    assign w_rnd_mag = r_mag + (OUT_W+1)'(r_g & (r_s | r_mag[0]));
`else
    assign w_rnd_mag = r_mag;
`endif
    assign w_rnd_ovf = r_ovf | w_rnd_mag[OUT_W];

    assign w_lim     = r_sign ? LIM_NEG : LIM_POS;
    assign w_sat     = r_inf | r_ovf | (r_mag > w_lim);
    assign w_sat_val = r_sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    assign w_signed  = r_sign ? (-r_mag[OUT_W-1:0]) : r_mag[OUT_W-1:0];

    always_comb begin
        w_next = r_state;
        if (RST_FSM_FF) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (Begin_FSM_FF) w_next = S_DECODE;
                S_DECODE: w_next = S_ALIGN;
                S_ALIGN:  w_next = S_ROUND;
                S_ROUND:  w_next = S_SAT;
                S_SAT:    w_next = S_DONE;
                S_DONE:   if (!Begin_FSM_FF) w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_FF_N) begin
        if (!RST_FF_N) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge CLK or negedge RST_FF_N) begin
        if (!RST_FF_N) begin
            r_op      <= '0;
            r_sign    <= 1'b0;
            r_zero    <= 1'b0;
            r_inf     <= 1'b0;
            r_nan     <= 1'b0;
            r_sig     <= '0;
            r_shift   <= '0;
            r_mag     <= '0;
            r_ovf     <= 1'b0;
            r_result  <= '0;
            r_ovf_out <= 1'b0;
            r_nan_out <= 1'b0;
`ifdef ROUND_NEAREST_EN
            r_g       <= 1'b0;
            r_s       <= 1'b0;
`endif
        end else if (!RST_FSM_FF) begin
            case (r_state)
                S_IDLE: if (Begin_FSM_FF) r_op <= F;
                S_DECODE: begin
                    r_sign  <= r_op[EXP_W+MAN_W];
                    r_sig   <= {1'b1, w_man};
                    r_shift <= w_shift;
                    r_zero  <= w_exp_zero;
                    r_inf   <= w_exp_ones & w_man_zero;
                    r_nan   <= w_exp_ones & ~w_man_zero;
                end
                S_ALIGN: begin
                    r_mag <= w_al_mag;
                    r_ovf <= w_al_ovf;
`ifdef ROUND_NEAREST_EN
                    r_g   <= w_al_g;
                    r_s   <= w_al_s;
`endif
                end
                S_ROUND: begin
                    r_mag <= w_rnd_mag;
                    r_ovf <= w_rnd_ovf;
                end
                S_SAT: begin
                    // Class precedence: NaN, then zero/denormal flush, then saturation.
                    if (r_nan) begin
                        r_result  <= '0;
                        r_ovf_out <= 1'b0;
                        r_nan_out <= 1'b1;
                    end else if (r_zero) begin
                        r_result  <= '0;
                        r_ovf_out <= 1'b0;
                        r_nan_out <= 1'b0;
                    end else if (w_sat) begin
                        r_result  <= w_sat_val;
                        r_ovf_out <= 1'b1;
                        r_nan_out <= 1'b0;
                    end else begin
                        r_result  <= w_signed;
                        r_ovf_out <= 1'b0;
                        r_nan_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ACK_FF = r_ack;
    assign RESULT = r_result;
    assign OVF_FF = r_ovf_out;
    assign NAN_FF = r_nan_out;

endmodule

// File: tb/tb_float_to_fixed_param.sv
// Self-checking bench for float_to_fixed_param (default single-precision -> Q8.24).
// Honours ROUND_NEAREST_EN the same way as the design.
module tb_float_to_fixed_param;

    logic        CLK = 1'b0;
    logic        RST_FF_N;
    logic        RST_FSM_FF;
    logic        Begin_FSM_FF;
    logic [31:0] F;
    logic        ACK_FF;
    logic [31:0] RESULT;
    logic        OVF_FF;
    logic        NAN_FF;

    int checks   = 0;
    int failures = 0;

`ifdef ROUND_NEAREST_EN
    localparam logic [31:0] EXP_018 = 32'h00049BA6;
`else
    localparam logic [31:0] EXP_018 = 32'h00049BA5;
`endif

    localparam int NV = 12;
    logic [31:0] dv_f   [NV] = '{32'hBF800000, 32'h3F933333, 32'h41740000, 32'hC1740000,
                                 32'h3C9374BC, 32'h43480000, 32'hC3000000, 32'hFF800000,
                                 32'h7FC00000, 32'h00000001, 32'h7F800000, 32'h80000000};
    logic [31:0] dv_res [NV] = '{32'hFF000000, 32'h01266666, 32'h0F400000, 32'hF0C00000,
                                 EXP_018,      32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                                 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000000};
    logic        dv_ovf [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b0};
    logic        dv_nan [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b0};

    float_to_fixed_param #(
        .EXP_W (8),
        .MAN_W (23),
        .INT_W (8),
        .FRAC_W(24)
    ) dut (
        .CLK         (CLK),
        .RST_FF_N    (RST_FF_N),
        .RST_FSM_FF  (RST_FSM_FF),
        .Begin_FSM_FF(Begin_FSM_FF),
        .F           (F),
        .ACK_FF      (ACK_FF),
        .RESULT      (RESULT),
        .OVF_FF      (OVF_FF),
        .NAN_FF      (NAN_FF)
    );

    always #5 CLK = ~CLK;

    // Reference: exact real value scaled by 2^24, then truncated or rounded half-even.
    function automatic void model(input logic [31:0] f, output logic [31:0] res,
                                  output logic ovf, output logic nan);
        logic [7:0]  ex;
        logic [22:0] mn;
        real         x, fl, lim;
        longint      m;
        ex = f[30:23];
        mn = f[22:0];
        res = '0; ovf = 1'b0; nan = 1'b0;
        if (ex == 8'hFF) begin
            if (mn != 0) nan = 1'b1;
            else begin
                ovf = 1'b1;
                res = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
            end
        end else if (ex != 0) begin
            x  = (1.0 + real'(mn) / 8388608.0) * $pow(2.0, real'(int'(ex) - 127 + 24));
            fl = $floor(x);
`ifdef ROUND_NEAREST_EN
            if ((x - fl > 0.5) || ((x - fl == 0.5) && (fl - 2.0 * $floor(fl / 2.0) == 1.0)))
                fl = fl + 1.0;
`endif
            lim = f[31] ? 2147483648.0 : 2147483647.0;
            if (fl > lim) begin
                ovf = 1'b1;
                res = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
            end else begin
                m   = longint'(fl);
                res = f[31] ? 32'(-m) : 32'(m);
            end
        end
    endfunction

    // One-cycle Begin pulse; ACK sampled after edges 1..6, outputs after edge 5.
    task automatic run_conv(input logic [31:0] f, output logic [5:0] tr,
                            output logic [31:0] res, output logic ovf, output logic nan);
        @(negedge CLK);
        F = f;
        Begin_FSM_FF = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge CLK);
            #1;
            if (e == 0) begin
                Begin_FSM_FF = 1'b0;
                F = $urandom;
            end
            tr[e] = ACK_FF;
            if (e == 4) begin
                res = RESULT; ovf = OVF_FF; nan = NAN_FF;
            end
        end
    endtask

    task automatic test_reset();
        RST_FF_N = 1'b0; RST_FSM_FF = 1'b0; Begin_FSM_FF = 1'b0; F = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (ACK_FF !== 1'b0 || RESULT !== 32'h0 || OVF_FF !== 1'b0 || NAN_FF !== 1'b0) begin
            failures++;
            $display("FAIL reset: ack=%b res=%h ovf=%b nan=%b required 0 0 0 0",
                     ACK_FF, RESULT, OVF_FF, NAN_FF);
        end
        @(negedge CLK);
        RST_FF_N = 1'b1;
    endtask

    task automatic test_directed();
        logic [5:0] tr; logic [31:0] r; logic o, n;
        for (int i = 0; i < NV; i++) begin
            run_conv(dv_f[i], tr, r, o, n);
            checks++;
            if (r !== dv_res[i] || o !== dv_ovf[i] || n !== dv_nan[i]) begin
                failures++;
                $display("FAIL directed F=%h: res=%h ovf=%b nan=%b required %h %b %b",
                         dv_f[i], r, o, n, dv_res[i], dv_ovf[i], dv_nan[i]);
            end
            checks++;
            if (tr !== 6'b010000) begin
                failures++;
                $display("FAIL latency F=%h: ack trace=%b required 010000", dv_f[i], tr);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] tr; logic [31:0] r, er, f; logic o, n, eo, en;
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0:       f = $urandom;
                1:       f = {1'($urandom), 8'hFF, ($urandom_range(0, 1) == 0) ? 23'h0 : 23'($urandom)};
                2:       f = {1'($urandom), 8'h00, 23'($urandom)};
                default: f = {1'($urandom), 8'(95 + $urandom_range(0, 40)), 23'($urandom)};
            endcase
            model(f, er, eo, en);
            run_conv(f, tr, r, o, n);
            checks++;
            if (r !== er || o !== eo || n !== en || tr !== 6'b010000) begin
                failures++;
                $display("FAIL random F=%h: res=%h ovf=%b nan=%b ack=%b required %h %b %b 010000",
                         f, r, o, n, tr, er, eo, en);
            end
        end
    endtask

    task automatic test_begin_held();
        logic [9:1] tr;
        logic       late_ack;
        @(negedge CLK);
        F = 32'h41740000;
        Begin_FSM_FF = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge CLK);
            #1;
            if (e == 1) F = $urandom;
            if (e == 8) Begin_FSM_FF = 1'b0;
            tr[e] = ACK_FF;
        end
        checks++;
        if (tr !== 9'b011110000) begin
            failures++;
            $display("FAIL begin_held: ack trace(9..1)=%b required 011110000", tr);
        end
        late_ack = 1'b0;
        repeat (8) begin
            @(posedge CLK);
            #1;
            late_ack |= ACK_FF;
        end
        checks++;
        if (late_ack !== 1'b0 || RESULT !== 32'h0F400000) begin
            failures++;
            $display("FAIL begin_held_rerun: late ack=%b res=%h required 0 0f400000", late_ack, RESULT);
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] tr; logic [31:0] r; logic o, n, late_ack;
        run_conv(32'hFF800000, tr, r, o, n);
        @(negedge CLK);
        F = 32'h3F933333;
        Begin_FSM_FF = 1'b1;
        @(posedge CLK);
        #1 Begin_FSM_FF = 1'b0;
        @(posedge CLK);
        #2 RST_FF_N = 1'b0;
        #1;
        checks++;
        if (ACK_FF !== 1'b0 || RESULT !== 32'h0 || OVF_FF !== 1'b0 || NAN_FF !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: ack=%b res=%h ovf=%b nan=%b required 0 0 0 0",
                     ACK_FF, RESULT, OVF_FF, NAN_FF);
        end
        @(negedge CLK);
        RST_FF_N = 1'b1;
        late_ack = 1'b0;
        repeat (8) begin
            @(posedge CLK);
            #1;
            late_ack |= ACK_FF;
        end
        checks++;
        if (late_ack !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_idle: ack seen=%b required 0", late_ack);
        end
        run_conv(32'h3F933333, tr, r, o, n);
        checks++;
        if (r !== 32'h01266666 || o !== 1'b0 || n !== 1'b0 || tr !== 6'b010000) begin
            failures++;
            $display("FAIL async_reset_after: res=%h ovf=%b nan=%b ack=%b required 01266666 0 0 010000",
                     r, o, n, tr);
        end
    endtask

    task automatic test_fsm_clear();
        logic [5:0] tr; logic [31:0] r; logic o, n, late_ack;
        run_conv(32'h41740000, tr, r, o, n);
        @(negedge CLK);
        F = 32'hBF800000;
        Begin_FSM_FF = 1'b1;
        @(posedge CLK);
        #1 Begin_FSM_FF = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_FSM_FF = 1'b1;
        @(posedge CLK);
        #1 RST_FSM_FF = 1'b0;
        late_ack = 1'b0;
        repeat (8) begin
            @(posedge CLK);
            #1;
            late_ack |= ACK_FF;
        end
        checks++;
        if (late_ack !== 1'b0 || RESULT !== 32'h0F400000) begin
            failures++;
            $display("FAIL fsm_clear: ack seen=%b res=%h required 0 0f400000", late_ack, RESULT);
        end
        @(negedge CLK);
        Begin_FSM_FF = 1'b1;
        RST_FSM_FF = 1'b1;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        RST_FSM_FF = 1'b0;
        late_ack = 1'b0;
        repeat (8) begin
            @(posedge CLK);
            #1;
            late_ack |= ACK_FF;
        end
        checks++;
        if (late_ack !== 1'b0) begin
            failures++;
            $display("FAIL fsm_clear_priority: ack seen=%b required 0", late_ack);
        end
        run_conv(32'hC1740000, tr, r, o, n);
        checks++;
        if (r !== 32'hF0C00000 || o !== 1'b0 || n !== 1'b0 || tr !== 6'b010000) begin
            failures++;
            $display("FAIL fsm_clear_after: res=%h ovf=%b nan=%b ack=%b required f0c00000 0 0 010000",
                     r, o, n, tr);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_begin_held();
        test_async_reset();
        test_fsm_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
